// File: rtl/multibyte_add_sequencer.sv
// Wide add/subtract built from one shared external 8-bit adder slice, one byte per clock, LSB first.
// Optional signed saturation of the final result is enabled by defining MULTIBYTE_ADD_SAT_EN.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                sub,
  output logic [7:0]          fa_a,
  output logic [7:0]          fa_b,
  output logic                fa_cin,
  input  logic [7:0]          fa_sum,
  input  logic                fa_cout,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                overflow,
  output logic                done_valid,
  input  logic                done_ready,
  output logic                busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          sub_q;
  logic          carry_q;
  logic [W-1:0]  a_shift;
  logic [W-1:0]  b_shift;
  logic          last_byte;
  logic          ovf_next;

  assign start_ready = (state == S_IDLE);
  assign done_valid  = (state == S_DONE);
  assign busy        = (state == S_RUN) || (state == S_DONE);

  assign a_shift   = a_q >> {idx, 3'b000};
  assign b_shift   = b_q >> {idx, 3'b000};
  assign last_byte = (idx == IW'(NBYTES - 1));

  // Signed overflow from the top byte: operands agree in sign but the sum does not.
  assign ovf_next = (a_q[W-1] ~^ (b_q[W-1] ^ sub_q)) & (fa_sum[7] ^ a_q[W-1]);

  always_comb begin
    fa_a   = '0;
    fa_b   = '0;
    fa_cin = 1'b0;
    if (state == S_RUN) begin
      fa_a   = a_shift[7:0];
      fa_b   = b_shift[7:0] ^ {8{sub_q}};
      fa_cin = (idx == '0) ? sub_q : carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            a_q    <= op_a;
            b_q    <= op_b;
            sub_q  <= sub;
            idx    <= '0;
            result <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) result[8*i +: 8] <= fa_sum;
          end
          carry_q <= fa_cout;
          if (last_byte) begin
            idx       <= '0;
            carry_out <= fa_cout;
            overflow  <= ovf_next;
            state     <= S_DONE;
`ifdef MULTIBYTE_ADD_SAT_EN
            if (ovf_next) begin
              result <= a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (done_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench for multibyte_add_sequencer: directed cases, backpressure, mid-run reset and random ops
// against a plain-arithmetic reference model; the shared adder slice is modelled here.
module tb_multibyte_add_sequencer;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic [7:0]   fa_a;
  logic [7:0]   fa_b;
  logic         fa_cin;
  logic [7:0]   fa_sum;
  logic         fa_cout;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         done_valid;
  logic         done_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] cin_seq;

  always #5 clk = ~clk;

  // The external combinational adder slice.
  logic [8:0] fa_full;
  assign fa_full = {1'b0, fa_a} + {1'b0, fa_b} + {8'b0, fa_cin};
  assign fa_sum  = fa_full[7:0];
  assign fa_cout = fa_full[8];

  multibyte_add_sequencer #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
  );

  // Reference: exact signed/unsigned arithmetic in 64 bits; returns {overflow, carry, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb, t, maxv, minv;
    logic [63:0] ua, ub;
    logic [W-1:0] res;
    logic cy, ov;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -maxv - 1;
    t    = s ? (sa - sb) : (sa + sb);
    ov   = (t > maxv) || (t < minv);
    res  = W'(t);
    cy   = s ? (ua >= ub) : (((ua + ub) >> W) != 0);
`ifdef MULTIBYTE_ADD_SAT_EN
    if (ov) res = (t > 0) ? W'(maxv) : W'(minv);
`endif
    return {ov, cy, res};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an op and hold start_valid until the accepting edge; returns in the first RUN cycle.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    op_a = a;
    op_b = b;
    sub = s;
    start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("accept_timeout", 64'(n < 20), 64'd1);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    cin_seq = '0;
    while (!done_valid && lat < 50) begin
      if (lat < 8) cin_seq[lat] = fa_cin;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int lat;
    logic [W+1:0] exp;
    done_ready = 1'b1;
    apply_stimulus(a, b, s);
    wait_done(lat);
    exp = model(a, b, s);
    check_output({tag, "_latency"}, 64'(lat), 64'(NBYTES));
    check_output({tag, "_result"}, 64'(result), 64'(exp[W-1:0]));
    check_output({tag, "_carry"}, 64'(carry_out), 64'(exp[W]));
    check_output({tag, "_ovf"}, 64'(overflow), 64'(exp[W+1]));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [W+1:0] exp;
    logic [W-1:0] ra, rb;
    logic rs;

    rst = 1'b1;
    start_valid = 1'b0;
    done_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_output("rst_start_ready", 64'(start_ready), 64'd1);
    check_output("rst_done_valid", 64'(done_valid), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_result", 64'(result), 64'd0);
    check_output("rst_fa_a", 64'(fa_a), 64'd0);
    check_output("rst_fa_b", 64'(fa_b), 64'd0);
    check_output("rst_fa_cin", 64'(fa_cin), 64'd0);

    run_op("ff_plus_1", 32'h000000FF, 32'h00000001, 1'b0);
    check_output("ff_plus_1_cin_seq", 64'(cin_seq[3:0]), 64'h2);
    check_output("ff_plus_1_const", 64'(result), 64'h100);

    run_op("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_op("pos_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0);
`ifdef MULTIBYTE_ADD_SAT_EN
    check_output("pos_ovf_const", 64'(result), 64'h7FFFFFFF);
`else
    check_output("pos_ovf_const", 64'(result), 64'h80000000);
`endif
    run_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b1);
    check_output("sub_borrow_cin_seq", 64'(cin_seq[3:0]), 64'h1);
    run_op("neg_ovf", 32'h80000000, 32'h00000001, 1'b1);
`ifdef MULTIBYTE_ADD_SAT_EN
    check_output("neg_ovf_const", 64'(result), 64'h80000000);
`else
    check_output("neg_ovf_const", 64'(result), 64'h7FFFFFFF);
`endif

    // Backpressure: hold the result in DONE while a new request waits.
    done_ready = 1'b0;
    apply_stimulus(32'h12345678, 32'h11111111, 1'b0);
    wait_done(lat);
    exp = model(32'h12345678, 32'h11111111, 1'b0);
    check_output("bp_latency", 64'(lat), 64'(NBYTES));
    op_a = 32'hCAFEF00D;
    op_b = 32'h0BADBEEF;
    sub = 1'b1;
    start_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("bp_hold_result", 64'(result), 64'(exp[W-1:0]));
      check_output("bp_hold_carry", 64'(carry_out), 64'(exp[W]));
      check_output("bp_hold_valid", 64'(done_valid), 64'd1);
      check_output("bp_hold_start_ready", 64'(start_ready), 64'd0);
    end
    done_ready = 1'b1;
    @(negedge clk);
    check_output("bp_release_valid", 64'(done_valid), 64'd0);
    check_output("bp_release_start_ready", 64'(start_ready), 64'd1);
    @(negedge clk);
    start_valid = 1'b0;
    check_output("bp_new_busy", 64'(busy), 64'd1);
    check_output("bp_new_start_ready", 64'(start_ready), 64'd0);
    wait_done(lat);
    exp = model(32'hCAFEF00D, 32'h0BADBEEF, 1'b1);
    check_output("bp_new_latency", 64'(lat), 64'(NBYTES));
    check_output("bp_new_result", 64'(result), 64'(exp[W-1:0]));
    check_output("bp_new_carry", 64'(carry_out), 64'(exp[W]));
    @(negedge clk);

    // Reset asserted during the second RUN cycle.
    done_ready = 1'b1;
    apply_stimulus(32'h01020304, 32'h10203040, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("midrst_busy", 64'(busy), 64'd0);
    check_output("midrst_result", 64'(result), 64'd0);
    check_output("midrst_start_ready", 64'(start_ready), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seen = seen | done_valid;
      @(negedge clk);
    end
    check_output("midrst_no_done", 64'(seen), 64'd0);
    run_op("after_rst", 32'h01020304, 32'h10203040, 1'b0);
    check_output("after_rst_const", 64'(result), 64'h11223344);

    // Random operations with random consumer delay.
    for (int k = 0; k < 12; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      done_ready = 1'b0;
      apply_stimulus(ra, rb, rs);
      wait_done(lat);
      exp = model(ra, rb, rs);
      check_output("rand_latency", 64'(lat), 64'(NBYTES));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check_output("rand_result", 64'(result), 64'(exp[W-1:0]));
      check_output("rand_carry", 64'(carry_out), 64'(exp[W]));
      check_output("rand_ovf", 64'(overflow), 64'(exp[W+1]));
      done_ready = 1'b1;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multibyte_add_sequencer.md
Name: multibyte_add_sequencer

Overview:
- Sequences one shared 8-bit ripple-carry adder slice to perform wide (8*NBYTES-bit) add/subtract, one byte per clock, LSB byte first.
- The adder stays a separate combinational instance. This block drives its A/B/Cin and registers its Sum/Cout, chaining the carry between bytes through a flop.
- Sits between an operand-issuing master (valid/ready) and a result consumer (valid/ready).

Parameters:
- NBYTES, 4, number of byte slices; operand/result width W = 8*NBYTES; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start_valid  input  1  operation request
- start_ready  output  1  request accepted when start_valid & start_ready
- op_a  input  W  operand A, sampled on accept
- op_b  input  W  operand B, sampled on accept
- sub  input  1  0 = A+B, 1 = A-B; sampled on accept
- fa_a  output  8  byte of A to adder
- fa_b  output  8  byte of B (inverted when sub) to adder
- fa_cin  output  1  adder carry-in
- fa_sum  input  8  adder sum (combinational return)
- fa_cout  input  1  adder carry-out
- result  output  W  registered result
- carry_out  output  1  final carry (for sub: 1 = no borrow)
- overflow  output  1  signed overflow
- done_valid  output  1  result available
- done_ready  input  1  consumer accepts result
- busy  output  1  high in RUN or DONE

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- States: IDLE, RUN, DONE. A byte counter idx of ceil(log2(NBYTES)) bits runs 0..NBYTES-1.
- Reset (rst sampled high at an edge, overrides everything, any state):
  - state=IDLE, idx=0.
  - result=0, carry_out=0, overflow=0, done_valid=0, busy=0.
  - Internal carry flop and operand registers = 0.
- start_ready = (state==IDLE), decoded combinationally; it is 1 after reset.
- IDLE -> RUN on accept:
  - Latch op_a, op_b, sub.
  - idx=0.
  - Clear result.
- RUN, each cycle:
  - fa_a = A byte[idx].
  - fa_b = B byte[idx] XOR {8{sub}}.
  - fa_cin = (idx==0) ? sub : carry flop.
  - At the edge: result byte[idx] <= fa_sum, carry flop <= fa_cout, idx++.
- RUN -> DONE at the edge where idx==NBYTES-1. At that edge:
  - carry_out <= fa_cout.
  - overflow <= (A[W-1] ~^ Beff[W-1]) & (fa_sum[7] ^ A[W-1]), where Beff[W-1] = B[W-1] ^ sub.
- Outside RUN: fa_a=0, fa_b=0, fa_cin=0.
- DONE:
  - done_valid=1.
  - result, carry_out and overflow are held stable until done_ready.
  - On done_valid & done_ready: transition to IDLE, done_valid=0 next cycle.
  - result, carry_out and overflow keep their last values in IDLE.
- Latency: done_valid is first seen high NBYTES edges after the accepting edge. Throughput is one op per NBYTES+2 cycles minimum, because no start is accepted in DONE.
- start_valid while busy is ignored; the requester holds it.
- Operand changes after accept have no effect.
- A glitch-free carry chain is not required. fa_sum/fa_cout are sampled only at clk edges.

Optional Feature:
- Macro: MULTIBYTE_ADD_SAT_EN.
- Defined: on the RUN->DONE edge, if the computed overflow is 1, result is forced to the signed saturation value:
  - 0x7F..FF when A[W-1]==0.
  - 0x80..00 when A[W-1]==1.
  - overflow is still reported as 1; carry_out is unchanged.
- Undefined: result is the raw wrapped sum. No saturation logic is present.

Test Plan (NBYTES=4):
- Reset, then idle with no start -> start_ready=1, done_valid=0, busy=0, result=0x00000000, fa_* all 0.
- A=0x000000FF, B=0x00000001, sub=0, done_ready=1 -> done_valid high exactly 4 edges after accept; result=0x00000100, carry_out=0, overflow=0. Check per-cycle fa_cin sequence 0,1,0,0.
- A=0xFFFFFFFF, B=0x00000001 -> result=0x00000000, carry_out=1, overflow=0. Then A=0x7FFFFFFF, B=0x00000001 -> overflow=1 with result=0x80000000, or result=0x7FFFFFFF with MULTIBYTE_ADD_SAT_EN.
- sub=1, A=0x00000005, B=0x00000007 -> result=0xFFFFFFFE, carry_out=0 (borrow), overflow=0. Then A=0x80000000, B=0x00000001 -> result=0x7FFFFFFF, overflow=1 (0x80000000 with SAT_EN).
- Backpressure: hold done_ready=0 for 3 cycles in DONE while start_valid=1 with new operands -> result, carry_out and done_valid stay stable, start_ready=0. Raise done_ready -> IDLE next cycle, new op accepted the cycle after.
- rst=1 on the 2nd RUN cycle of A=0x01020304, B=0x10203040 -> next cycle state IDLE, result=0, busy=0, done_valid never rises. A fresh op afterwards completes correctly: 0x11223344.
